uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one `uart_tx` byte transmitter among `NUM_REQ` independent requesters. Each requester offers a byte with a valid/ready handshake. The arbiter grants one byte at a time, drives the transmitter's `send`/`bit_value` inputs, and tracks the transmitter's `ready` output until the frame (start, 8 data bits, stop) completes. It sits directly upstream of `uart_tx` in the TX path and adds a launch watchdog.

---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the round-robin UART TX arbiter.
// The UART_ARB_TAG_EN build option uses ARB_TAG_BASE to form per-requester tag bytes.
package uart_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE       = 3'd0,
        ARB_TAG_LAUNCH = 3'd1,
        ARB_TAG_DRAIN  = 3'd2,
        ARB_LAUNCH     = 3'd3,
        ARB_DRAIN      = 3'd4
    } arb_state_t;

    localparam logic [7:0] ARB_TAG_BASE = 8'hA0;

    // Tag byte announcing which requester owns the following data byte.
    function automatic logic [7:0] arb_tag_byte(input logic [3:0] id);
        return ARB_TAG_BASE | {4'h0, id};
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: first set request scanning from ptr upward, wrapping at N.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [N-1:0] w_rot;
    int           w_sum;

    // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        any   = 1'b0;
        idx   = {IDW{1'b0}};
        w_sum = 0;
        w_rot = N'({req, req} >> ptr);
        for (int k = 0; k < N; k++) begin
            if (!any && w_rot[k]) begin
                any   = 1'b1;
                w_sum = int'(ptr) + k;
                idx   = (w_sum >= N) ? IDW'(w_sum - N) : IDW'(w_sum);
            end else begin
                any = any;
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ requesters, with a launch watchdog.
// Define UART_ARB_TAG_EN to prefix every granted byte with tag byte 8'hA0 | grant_id.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int ACK_TIMEOUT = 8,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_send,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [IDW-1:0]       grant_id,
    output logic                 active,
    output logic                 err_timeout
);

    localparam int             CW      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0]  WD_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0]  WD_MAX  = CW'(ACK_TIMEOUT);

    arb_state_t          r_state;
    logic [IDW-1:0]      r_ptr;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_req_ready;
    logic                r_tx_send;
    logic [7:0]          r_tx_data;
    logic [IDW-1:0]      r_grant_id;
    logic                r_active;
    logic                r_err_timeout;
`ifdef UART_ARB_TAG_EN
    logic [7:0]          r_hold;
`endif

    logic                w_any;
    logic [IDW-1:0]      w_idx;
    logic [NUM_REQ-1:0]  w_win_onehot;
    logic [7:0]          w_win_data;
    logic [IDW-1:0]      w_next_ptr;

    uart_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    assign w_win_onehot = NUM_REQ'(1'b1) << w_idx;
    assign w_win_data   = 8'(req_data >> {w_idx, 3'b000});
    assign w_next_ptr   = (r_grant_id == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}}
                                                            : r_grant_id + IDW'(1'b1);

    // Arbiter FSM, watchdog and all registered outputs.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state       <= ARB_IDLE;
            r_ptr         <= {IDW{1'b0}};
            r_cnt         <= {CW{1'b0}};
            r_req_ready   <= {NUM_REQ{1'b0}};
            r_tx_send     <= 1'b0;
            r_tx_data     <= 8'h00;
            r_grant_id    <= {IDW{1'b0}};
            r_active      <= 1'b0;
            r_err_timeout <= 1'b0;
`ifdef UART_ARB_TAG_EN
            r_hold        <= 8'h00;
`endif
        end else begin
            r_req_ready   <= {NUM_REQ{1'b0}};
            r_err_timeout <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_any && tx_ready) begin
                        r_req_ready <= w_win_onehot;
                        r_grant_id  <= w_idx;
                        r_tx_send   <= 1'b1;
                        r_cnt       <= {CW{1'b0}};
                        r_active    <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        r_hold      <= w_win_data;
                        r_tx_data   <= arb_tag_byte(4'(w_idx));
                        r_state     <= ARB_TAG_LAUNCH;
`else
                        r_tx_data   <= w_win_data;
                        r_state     <= ARB_LAUNCH;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                ARB_TAG_LAUNCH,
`endif
                ARB_LAUNCH: begin
                    if (!tx_ready) begin
                        r_tx_send <= 1'b0;
                        r_cnt     <= {CW{1'b0}};
`ifdef UART_ARB_TAG_EN
                        r_state   <= (r_state == ARB_TAG_LAUNCH) ? ARB_TAG_DRAIN : ARB_DRAIN;
`else
                        r_state   <= ARB_DRAIN;
`endif
                    end else if (r_cnt == WD_LAST) begin
                        // Transmitter never acknowledged: drop the byte and move on.
                        r_tx_send     <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_cnt         <= {CW{1'b0}};
                        r_ptr         <= w_next_ptr;
                        r_active      <= 1'b0;
                        r_state       <= ARB_IDLE;
                    end else if (r_cnt != WD_MAX) begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
`ifdef UART_ARB_TAG_EN
                ARB_TAG_DRAIN: begin
                    if (tx_ready) begin
                        r_tx_data <= r_hold;
                        r_tx_send <= 1'b1;
                        r_cnt     <= {CW{1'b0}};
                        r_state   <= ARB_LAUNCH;
                    end
                end
`endif
                ARB_DRAIN: begin
                    if (tx_ready) begin
                        r_ptr    <= w_next_ptr;
                        r_active <= 1'b0;
                        r_state  <= ARB_IDLE;
                    end
                end
                default: begin
                    r_tx_send <= 1'b0;
                    r_cnt     <= {CW{1'b0}};
                    r_active  <= 1'b0;
                    r_state   <= ARB_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign tx_send     = r_tx_send;
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign active      = r_active;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: behavioural uart_tx model, round-robin reference
// model and byte scoreboard; also covers the UART_ARB_TAG_EN build when that macro is defined.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int TMO   = 8;
    localparam int FRAME = 20;

    logic             clk = 1'b0;
    logic             rstn;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             tx_send;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic [1:0]       grant_id;
    logic             active;
    logic             err_timeout;

    int               checks = 0;
    int               errors = 0;
    int               ptr_m  = 0;
    logic             tie_ready = 1'b0;
    int               m_cnt;
    logic [7:0]       act_q[$];
    logic [7:0]       exp_q[$];

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural uart_tx: accepts send when idle, drops ready two clocks later, frame lasts FRAME clocks.
    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            m_cnt    <= 0;
            tx_ready <= 1'b1;
            act_q.delete();
        end else if (tie_ready) begin
            m_cnt    <= 0;
            tx_ready <= 1'b1;
        end else if (m_cnt == 0) begin
            if (tx_send) begin
                m_cnt <= FRAME + 2;
                act_q.push_back(tx_data);
            end
            tx_ready <= 1'b1;
        end else begin
            m_cnt    <= m_cnt - 1;
            tx_ready <= (m_cnt - 1 > FRAME) || (m_cnt - 1 == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference winner: first valid requester scanning p, p+1, ... modulo N.
    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic run_traffic(input logic [N-1:0] mask, input logic [8*N-1:0] data, input bit inject);
        int   w;
        int   b;
        int   injected = 0;
        int   cyc = 0;
        bit   done = 1'b0;
        logic prev_send;
        logic [7:0] byte_v;
        req_data  = data;
        req_valid = mask;
        prev_send = tx_send;
        while (!done && cyc < 4000) begin
            tick();
            cyc++;
            if (tx_send && !prev_send) check("send_only_when_ready", 32'(tx_ready), 32'd1);
            prev_send = tx_send;
            if (req_ready != '0) begin
                w = pick(ptr_m, req_valid);
                check("grant_onehot", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
                check("grant_id", 32'(grant_id), 32'(w));
                check("grant_active", 32'(active), 32'd1);
                if (w >= 0) begin
                    byte_v = req_data[8*w +: 8];
`ifdef UART_ARB_TAG_EN
                    check("grant_tag", 32'(tx_data), 32'(8'hA0 | 8'(w)));
                    exp_q.push_back(8'hA0 | 8'(w));
`else
                    check("grant_data", 32'(tx_data), 32'(byte_v));
`endif
                    exp_q.push_back(byte_v);
                    req_valid[w] = 1'b0;
                    ptr_m = (w + 1) % N;
                end
            end
            if (inject && injected < 3 && $urandom_range(0, 7) == 0) begin
                b = $urandom_range(0, N - 1);
                if (!req_valid[b]) begin
                    req_data[8*b +: 8] = 8'($urandom);
                    req_valid[b] = 1'b1;
                    injected++;
                end
            end
            done = (req_valid == '0) && !active && tx_ready && !tx_send;
        end
        check("traffic_done", 32'(done), 32'd1);
        check("byte_count", 32'(act_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            check("tx_byte", 32'(act_q.pop_front()), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_tx_send"}, 32'(tx_send), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_active"}, 32'(active), 32'd0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    task automatic pulse_reset();
        rstn = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        rstn  = 1'b0;
        ptr_m = 0;
        exp_q.delete();
    endtask

    initial begin
        int         n;
        int         cyc;
        logic [8*N-1:0] d;

        rstn      = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b0;

        // Single request from requester 2, then wrap with ptr at 3.
        run_traffic(4'b0100, {8'h00, 8'h5A, 8'h00, 8'h00}, 1'b0);
        run_traffic(4'b1001, {8'hD3, 8'h00, 8'h00, 8'h3C}, 1'b0);

        // All four valid straight out of reset.
        pulse_reset();
        run_traffic(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b0);

        // Random masks and data with requests arriving mid-frame.
        for (int r = 0; r < 8; r++) begin
            d = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            run_traffic(4'($urandom_range(1, 15)), d, 1'b1);
        end

        run_traffic(4'b0010, {8'h00, 8'h00, 8'h33, 8'h00}, 1'b0);

        // Watchdog: transmitter never drops ready.
        tie_ready = 1'b1;
        req_data  = {8'h00, 8'h00, 8'h77, 8'h00};
        req_valid = 4'b0010;
        cyc = 0;
        while (req_ready == '0 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("wd_grant", 32'(req_ready), 32'h2);
        check("wd_grant_id", 32'(grant_id), 32'd1);
        check("wd_send_rise", 32'(tx_send), 32'd1);
        req_valid = '0;
        n = 0;
        while (!err_timeout && n < 50) begin
            tick();
            n++;
        end
        check("wd_latency", 32'(n), 32'(TMO));
        check("wd_send_low", 32'(tx_send), 32'd0);
        check("wd_active_low", 32'(active), 32'd0);
        tick();
        check("wd_pulse_width", 32'(err_timeout), 32'd0);
        ptr_m     = 2;
        tie_ready = 1'b0;
        run_traffic(4'b0101, {8'h00, 8'h9E, 8'h00, 8'h61}, 1'b0);

        // Reset during DRAIN; requester 0 keeps its byte pending across the reset.
        req_data  = {8'h00, 8'h00, 8'h00, 8'hC3};
        req_valid = 4'b0001;
        cyc = 0;
        while (!(active && !tx_send && req_ready == '0 && m_cnt > 0) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("rst_reached_drain", 32'(active && !tx_send), 32'd1);
        rstn = 1'b1;
        #1;
        check_reset_outputs("midframe_reset");
        tick();
        @(negedge clk);
        rstn  = 1'b0;
        ptr_m = 0;
        exp_q.delete();
        run_traffic(4'b0001, {8'h00, 8'h00, 8'h00, 8'hC3}, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
